// File: rtl/video_timing_monitor.sv
// Sink-side raster monitor: measures line/frame geometry per frame,
// reports stable-mode lock and loss of vsync.
module video_timing_monitor #(
  parameter int CW            = 12,
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT_CLKS  = 2000000,
  parameter bit SYNC_ACT_HIGH = 1'b1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          hsync,
  input  logic          vsync,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          frame_strobe,
  output logic          locked,
  output logic          no_signal
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [SW-1:0] SMAX  = SW'(STABLE_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [CW-1:0] hcnt_q, hcnt_d, line_len_q, line_len_d;
  logic [CW-1:0] acnt_q, acnt_d, line_act_q, line_act_d;
  logic [CW-1:0] vcnt_q, vcnt_d, vact_q, vact_d;
  logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic          arm_q, arm_d, prev_valid_q, prev_valid_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          strobe_q, strobe_d, locked_q, locked_d;
  logic          no_signal_q, no_signal_d;
  logic          hs_n, vs_n, de, hs_e, vs_e, match;

  assign hs_n = SYNC_ACT_HIGH ? hsync : ~hsync;
  assign vs_n = SYNC_ACT_HIGH ? vsync : ~vsync;
  assign de   = ~(hblank | vblank);
  assign hs_e = ce_pix & hs_n & ~hs_prev_q;
  assign vs_e = ce_pix & vs_n & ~vs_prev_q;

  always_comb begin
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    hcnt_d       = hcnt_q;
    line_len_d   = line_len_q;
    acnt_d       = acnt_q;
    line_act_d   = line_act_q;
    vcnt_d       = vcnt_q;
    vact_d       = vact_q;
    h_total_d    = h_total_q;
    h_active_d   = h_active_q;
    v_total_d    = v_total_q;
    v_active_d   = v_active_q;
    arm_d        = arm_q;
    prev_valid_d = prev_valid_q;
    stable_cnt_d = stable_cnt_q;
    strobe_d     = 1'b0;
    locked_d     = locked_q;
    no_signal_d  = no_signal_q;
    match        = 1'b0;
    tcnt_d       = (tcnt_q == TLAST) ? tcnt_q : tcnt_q + 1'b1;

    if (ce_pix) begin
      hs_prev_d = hs_n;
      vs_prev_d = vs_n;
      if (hs_e) begin
        line_len_d = hcnt_q;
        hcnt_d     = {{(CW-1){1'b0}}, 1'b1};
        if (acnt_q != '0) begin
          line_act_d = acnt_q;
          vact_d     = sat_inc(vact_q);
        end
        acnt_d = '0;
        vcnt_d = sat_inc(vcnt_q);
      end else begin
        hcnt_d = sat_inc(hcnt_q);
        if (de) acnt_d = sat_inc(acnt_q);
      end
    end

    // A coincident hsync edge is already folded into the *_d values
    // above, so that line belongs to the frame being closed.
    if (vs_e) begin
      tcnt_d      = '0;
      no_signal_d = 1'b0;
      if (arm_q) begin
        h_total_d  = line_len_d;
        h_active_d = line_act_d;
        v_total_d  = vcnt_d;
        v_active_d = vact_d;
        strobe_d   = 1'b1;
        match = prev_valid_q &&
                ({h_total_d, h_active_d, v_total_d, v_active_d} ==
                 {h_total_q, h_active_q, v_total_q, v_active_q});
        if (!match)                   stable_cnt_d = {{(SW-1){1'b0}}, 1'b1};
        else if (stable_cnt_q != SMAX) stable_cnt_d = stable_cnt_q + 1'b1;
        prev_valid_d = 1'b1;
        locked_d     = (stable_cnt_d == SMAX);
      end
      arm_d  = 1'b1;
      vcnt_d = '0;
      vact_d = '0;
    end else if (tcnt_q == TLAST) begin
      no_signal_d  = 1'b1;
      locked_d     = 1'b0;
      stable_cnt_d = '0;
      arm_d        = 1'b0;
      prev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      hcnt_q       <= '0;
      line_len_q   <= '0;
      acnt_q       <= '0;
      line_act_q   <= '0;
      vcnt_q       <= '0;
      vact_q       <= '0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
      arm_q        <= 1'b0;
      prev_valid_q <= 1'b0;
      stable_cnt_q <= '0;
      tcnt_q       <= '0;
      strobe_q     <= 1'b0;
      locked_q     <= 1'b0;
      no_signal_q  <= 1'b0;
    end else begin
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      hcnt_q       <= hcnt_d;
      line_len_q   <= line_len_d;
      acnt_q       <= acnt_d;
      line_act_q   <= line_act_d;
      vcnt_q       <= vcnt_d;
      vact_q       <= vact_d;
      h_total_q    <= h_total_d;
      h_active_q   <= h_active_d;
      v_total_q    <= v_total_d;
      v_active_q   <= v_active_d;
      arm_q        <= arm_d;
      prev_valid_q <= prev_valid_d;
      stable_cnt_q <= stable_cnt_d;
      tcnt_q       <= tcnt_d;
      strobe_q     <= strobe_d;
      locked_q     <= locked_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign h_total      = h_total_q;
  assign h_active     = h_active_q;
  assign v_total      = v_total_q;
  assign v_active     = v_active_q;
  assign frame_strobe = strobe_q;
  assign locked       = locked_q;
  assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Randomised raster bench for video_timing_monitor; expectations come
// from frame geometry, not from sample-level counting.
module tb_video_timing_monitor;

  localparam int CW = 12;
  localparam int SF = 4;
  localparam int TO = 8000;
  localparam int SAT = 4095;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce_pix = 1'b0;
  logic hblank = 1'b1, vblank = 1'b1;
  logic hsync = 1'b0, vsync = 1'b0;
  logic [CW-1:0] h_total, h_active, v_total, v_active;
  logic frame_strobe, locked, no_signal;

  video_timing_monitor #(
    .CW(CW), .STABLE_FRAMES(SF),
    .TIMEOUT_CLKS(TO), .SYNC_ACT_HIGH(1'b1)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync),
    .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active),
    .frame_strobe(frame_strobe), .locked(locked),
    .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h, ha, hs, v, va, vsp;
    bit co;
  } geom_t;

  typedef struct packed {
    logic [CW-1:0] ht, ha, vt, va;
    logic lk;
  } meas_t;

  meas_t q[$];
  always @(negedge clk)
    if (frame_strobe)
      q.push_back({h_total, h_active, v_total, v_active, locked});

  int checks = 0, errors = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // frame-level reference state
  bit    armed = 0, pvalid = 0;
  int    run = 0;
  int    pt[4];
  geom_t pg;
  int    idle_max = 1;
  bit    prev_vs_drv = 0;
  int    last_vs_cyc = 0;

  function automatic geom_t rgeom();
    geom_t g;
    g.h   = $urandom_range(16, 28);
    g.ha  = $urandom_range(8, g.h - 6);
    g.hs  = g.ha + $urandom_range(1, 2);
    g.v   = $urandom_range(12, 16);
    g.va  = $urandom_range(4, g.v - 4);
    g.vsp = $urandom_range(0, g.hs - 1);
    g.co  = 1'b0;
    return g;
  endfunction

  task automatic put(bit hb, bit vb, bit hs, bit vs);
    int n;
    n = $urandom_range(0, idle_max);
    repeat (n) begin
      ce_pix = 1'b0;
      hsync  = 1'($urandom);
      vsync  = 1'($urandom);
      hblank = 1'($urandom);
      vblank = 1'($urandom);
      @(posedge clk); #1;
    end
    ce_pix = 1'b1;
    hblank = hb; vblank = vb;
    hsync  = hs; vsync  = vs;
    @(posedge clk); #1;
    if (vs && !prev_vs_drv) last_vs_cyc = cyc;
    prev_vs_drv = vs;
    ce_pix = 1'b0;
  endtask

  task automatic send_frame(geom_t g, int gap);
    int sv_idle, v0, s;
    sv_idle  = idle_max;
    idle_max = 0;
    for (int i = 0; i < gap; i++) put(1'b1, 1'b1, 1'b0, 1'b0);
    idle_max = sv_idle;
    v0 = g.co ? g.hs : g.vsp;
    for (int l = 0; l < g.v; l++)
      for (int p = 0; p < g.h; p++) begin
        s = l * g.h + p;
        put(p >= g.ha, l < g.v - g.va,
            (p >= g.hs) && (p < g.hs + 2),
            (s >= v0) && (s < v0 + g.h / 2));
      end
  endtask

  task automatic model_frame(geom_t g, int gap);
    int e[4];
    meas_t m;
    if (!armed) begin
      armed = 1;
      check("arm_nostrobe", q.size(), 0);
    end else begin
      e[0] = g.co ? pg.h - pg.hs + gap + g.hs : pg.h;
      if (e[0] > SAT) e[0] = SAT;
      e[1] = pg.ha;
      e[2] = pg.v - int'(pg.co) + int'(g.co);
      e[3] = pg.va;
      if (pvalid && e == pt) run = (run < SF) ? run + 1 : SF;
      else run = 1;
      pvalid = 1;
      pt = e;
      check("strobe_cnt", q.size(), 1);
      if (q.size() > 0) begin
        m = q.pop_front();
        check("h_total", m.ht, e[0]);
        check("h_active", m.ha, e[1]);
        check("v_total", m.vt, e[2]);
        check("v_active", m.va, e[3]);
        check("locked", m.lk, run == SF);
      end
    end
    q.delete();
    pg = g;
    check("no_signal", no_signal, 0);
  endtask

  task automatic frame(geom_t g, int gap);
    send_frame(g, gap);
    model_frame(g, gap);
  endtask

  task automatic model_unlock();
    armed = 0; pvalid = 0; run = 0;
  endtask

  task automatic zero_chk(string tag);
    check(tag, {h_total, h_active, v_total, v_active,
                frame_strobe, locked, no_signal}, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    geom_t g1, g2, g5, g6;
    int t0;
    repeat (3) @(posedge clk);
    #1;
    zero_chk("reset_state");
    reset_n = 1'b1;

    // nominal raster: arm, then lock on 4th strobe
    g1 = rgeom();
    for (int i = 0; i < 6; i++) frame(g1, 0);

    // taller frames: lock drops, then relocks
    g2 = g1;
    g2.v = g1.v + 3;
    for (int i = 0; i < 6; i++) frame(g2, 0);

    // loss of vsync
    hsync = 1'b0; vsync = 1'b0; prev_vs_drv = 1'b0;
    t0 = cyc;
    while (!no_signal && cyc - t0 < TO + 2000) begin
      @(posedge clk); #1;
    end
    check("timeout_lat", cyc - last_vs_cyc, TO);
    check("timeout_lock", locked, 0);
    check("timeout_ht", h_total, pt[0]);
    check("timeout_ha", h_active, pt[1]);
    check("timeout_vt", v_total, pt[2]);
    check("timeout_va", v_active, pt[3]);
    check("timeout_nostrobe", q.size(), 0);
    model_unlock();
    for (int i = 0; i < 6; i++) frame(g1, 0);

    // async reset in the middle of a frame
    fork
      send_frame(g1, 0);
      begin
        repeat (3 * g1.h) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 zero_chk("midframe_reset");
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
      end
    join
    model_frame(g1, 0);
    model_unlock();
    for (int i = 0; i < 3; i++) frame(g1, 0);

    // vsync edge coincident with hsync edge
    g5 = g1;
    g5.co = 1'b1;
    for (int i = 0; i < 5; i++) frame(g5, 0);

    // overlong line saturates h_total
    frame(g5, 4100);
    frame(g5, 0);

    // heavier ce_pix gaps on a fresh raster
    idle_max = 3;
    g6 = rgeom();
    for (int i = 0; i < 6; i++) frame(g6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
